verin_pio_sequencer: RTL and testbench

Round-robin write sequencer that shares the single 8-bit output PIO (actuator command register) between up to NUM_REQ requesters. Each requester posts a byte with a one-cycle request pulse. The sequencer serialises the posted bytes into Avalon-MM writes to PIO address 0, reads each one back, and returns a per-requester acknowledge with a mismatch flag. It sits between the actuator-control logic and the PIO slave port, and it is the only master on that port.

---
 rtl/verin_pio_sequencer_if.sv | 25 ++
 rtl/verin_pio_sequencer.sv | 148 ++++++++++++++
 tb/tb_verin_pio_sequencer.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/verin_pio_sequencer_if.sv
// Avalon-MM style bus between the write sequencer (master) and the
// actuator-command PIO slave port.
interface verin_pio_sequencer_if;
  logic [1:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;
  logic [31:0] pio_readdata;

  modport master (
    output pio_address,
    output pio_chipselect,
    output pio_write_n,
    output pio_writedata,
    input  pio_readdata
  );

  modport slave (
    input  pio_address,
    input  pio_chipselect,
    input  pio_write_n,
    input  pio_writedata,
    output pio_readdata
  );
endinterface

// File: rtl/verin_pio_sequencer.sv
// Round-robin sequencer that serialises per-requester bytes into PIO writes,
// reads each back and returns a per-requester ack with a mismatch flag.
module verin_pio_sequencer #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     ack,
  output logic                   err,
  output logic                   busy,
  output logic [7:0]             cur_value,
  verin_pio_sequencer_if.master  pio
);

  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [NUM_REQ-1:0] r_pending;
  logic [NUM_REQ-1:0] w_pending_nxt;
  logic [NUM_REQ-1:0] w_clear;
  logic [7:0]         r_hold [NUM_REQ];
  logic [PW-1:0]      r_ptr;
  logic [PW-1:0]      r_gnt;
  logic [PW-1:0]      w_gidx;
  logic               w_found;
  logic               w_grant;
  logic               w_busy_nxt;
  logic [7:0]         r_byte;
  logic [7:0]         r_cur;
  logic [NUM_REQ-1:0] r_ack;
  logic               r_err;
  logic               r_busy;
  logic               r_cs;
  logic               r_wr_n;
  logic               w_readdata_unused;

  function automatic logic [PW-1:0] wrap_idx(input int unsigned v);
    return (v >= NUM_REQ) ? PW'(v - NUM_REQ) : PW'(v);
  endfunction

  // First pending index at or after the round-robin pointer, with wrap.
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!w_found && r_pending[wrap_idx(32'(r_ptr) + k)]) begin
        w_found = 1'b1;
        w_gidx  = wrap_idx(32'(r_ptr) + k);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_grant     = 1'b1;
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: w_state_nxt = S_READ;
      S_READ:  w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A request in the grant cycle re-arms its pending bit for a new transaction.
  always_comb begin
    w_clear       = w_grant ? (NUM_REQ'(1) << w_gidx) : '0;
    w_pending_nxt = (r_pending & ~w_clear) | req;
    w_busy_nxt    = (w_state_nxt != S_IDLE) || (|w_pending_nxt);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= '0;
      r_ptr     <= '0;
      r_gnt     <= '0;
      r_byte    <= '0;
      r_cur     <= '0;
      r_ack     <= '0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
      r_cs      <= 1'b0;
      r_wr_n    <= 1'b1;
      for (int unsigned i = 0; i < NUM_REQ; i++) r_hold[i] <= '0;
    end else begin
      r_pending <= w_pending_nxt;
      r_busy    <= w_busy_nxt;
      r_ack     <= '0;
      r_err     <= 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (req[i]) r_hold[i] <= req_data[8*i +: 8];
      end
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_gnt  <= w_gidx;
            r_byte <= r_hold[w_gidx];
            r_ptr  <= wrap_idx(32'(w_gidx) + 1);
            r_cs   <= 1'b1;
            r_wr_n <= 1'b0;
          end
        end
        S_WRITE: begin
          r_cur  <= r_byte;
          r_wr_n <= 1'b1;
        end
        // Read-back is compared at the capture edge so ack and err land together in DONE.
        S_READ: begin
          r_ack <= NUM_REQ'(1) << r_gnt;
          r_err <= (pio.pio_readdata[7:0] != r_byte);
          r_cs  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign ack                = r_ack;
  assign err                = r_err;
  assign busy               = r_busy;
  assign cur_value          = r_cur;
  assign pio.pio_address    = 2'b00;
  assign pio.pio_chipselect = r_cs;
  assign pio.pio_write_n    = r_wr_n;
  assign pio.pio_writedata  = {24'h0, r_byte};
  assign w_readdata_unused  = ^pio.pio_readdata[31:8];

endmodule

// File: tb/tb_verin_pio_sequencer.sv
// Self-checking bench for verin_pio_sequencer: directed scenarios plus a
// randomized run compared against a transaction-level reference model.
module tb_verin_pio_sequencer;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   ack;
  logic           err;
  logic           busy;
  logic [7:0]     cur_value;

  verin_pio_sequencer_if pio_if();

  logic [7:0] pio_reg = 8'h00;
  bit         force_bad;
  logic [7:0] wr_log[$];

  int n_checks;
  int n_errors;

  // Reference model: pending/hold per requester, pointer, and age of the
  // active transaction in cycles since its grant (0 = none in flight).
  bit         m_pend[N];
  logic [7:0] m_hold[N];
  int         m_ptr;
  int         m_a;
  int         m_g;
  logic [7:0] m_b;
  logic [7:0] m_cur;
  logic [N-1:0] e_ack;
  bit         e_err;

  verin_pio_sequencer #(.NUM_REQ(N)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .req_data  (req_data),
    .ack       (ack),
    .err       (err),
    .busy      (busy),
    .cur_value (cur_value),
    .pio       (pio_if)
  );

  always #5 clk = ~clk;

  assign pio_if.pio_readdata = force_bad ? 32'h0 : {24'h0, pio_reg};

  always @(posedge clk) begin
    if (pio_if.pio_chipselect && !pio_if.pio_write_n) begin
      pio_reg <= pio_if.pio_writedata[7:0];
      wr_log.push_back(pio_if.pio_writedata[7:0]);
    end
  end

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 1'b0;
      m_hold[i] = 8'h00;
    end
    m_ptr = 0;
    m_a   = 0;
    m_g   = 0;
    m_b   = 8'h00;
    m_cur = 8'h00;
    e_ack = '0;
    e_err = 1'b0;
  endtask

  function automatic bit m_any();
    bit a = 1'b0;
    for (int i = 0; i < N; i++) a |= m_pend[i];
    return a;
  endfunction

  task automatic model_edge(input logic [N-1:0] r, input logic [8*N-1:0] d);
    int g = -1;
    e_ack = '0;
    e_err = 1'b0;
    if (m_a == 0) begin
      for (int k = 0; k < N; k++)
        if (g < 0 && m_pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      if (g >= 0) begin
        m_g       = g;
        m_b       = m_hold[g];
        m_pend[g] = 1'b0;
        m_ptr     = (g + 1) % N;
        m_a       = 1;
      end
    end else if (m_a == 1) begin
      m_a   = 2;
      m_cur = m_b;
    end else if (m_a == 2) begin
      m_a   = 3;
      e_ack = N'(1) << m_g;
      e_err = force_bad && (m_b != 8'h00);
    end else begin
      m_a = 0;
    end
    for (int i = 0; i < N; i++) begin
      if (r[i]) begin
        m_pend[i] = 1'b1;
        m_hold[i] = d[8*i +: 8];
      end
    end
  endtask

  task automatic step(input logic [N-1:0] r, input logic [8*N-1:0] d);
    req      = r;
    req_data = d;
    @(posedge clk);
    model_edge(r, d);
    @(negedge clk);
    req = '0;
  endtask

  task automatic apply_reset();
    reset_n   = 1'b0;
    req       = '0;
    req_data  = '0;
    force_bad = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if (ack !== '0) begin n_errors++; $display("FAIL rst_ack: got %b expected 0", ack); end
    n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL rst_err: got %b expected 0", err); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    n_checks++; if (cur_value !== 8'h00) begin n_errors++; $display("FAIL rst_cur: got %h expected 00", cur_value); end
    n_checks++; if (pio_if.pio_chipselect !== 1'b0) begin n_errors++; $display("FAIL rst_cs: got %b expected 0", pio_if.pio_chipselect); end
    n_checks++; if (pio_if.pio_write_n !== 1'b1) begin n_errors++; $display("FAIL rst_wn: got %b expected 1", pio_if.pio_write_n); end
    n_checks++; if (pio_if.pio_writedata !== 32'h0) begin n_errors++; $display("FAIL rst_wdata: got %h expected 0", pio_if.pio_writedata); end
    n_checks++; if (pio_if.pio_address !== 2'b00) begin n_errors++; $display("FAIL rst_addr: got %b expected 0", pio_if.pio_address); end
    step('0, '0);
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rst_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_single();
    logic [8*N-1:0] d;
    apply_reset();
    d = '0;
    d[15:8] = 8'hA5;
    step(4'b0010, d);
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL single_busy_c1: got %b expected 1", busy); end
    n_checks++; if (pio_if.pio_chipselect !== 1'b0) begin n_errors++; $display("FAIL single_cs_c1: got %b expected 0", pio_if.pio_chipselect); end
    step('0, '0);
    n_checks++; if (pio_if.pio_chipselect !== 1'b1) begin n_errors++; $display("FAIL single_cs_c2: got %b expected 1", pio_if.pio_chipselect); end
    n_checks++; if (pio_if.pio_write_n !== 1'b0) begin n_errors++; $display("FAIL single_wn_c2: got %b expected 0", pio_if.pio_write_n); end
    n_checks++; if (pio_if.pio_writedata !== 32'h000000A5) begin n_errors++; $display("FAIL single_wdata_c2: got %h expected 000000a5", pio_if.pio_writedata); end
    n_checks++; if (pio_if.pio_address !== 2'b00) begin n_errors++; $display("FAIL single_addr_c2: got %b expected 0", pio_if.pio_address); end
    step('0, '0);
    n_checks++; if (pio_if.pio_chipselect !== 1'b1) begin n_errors++; $display("FAIL single_cs_c3: got %b expected 1", pio_if.pio_chipselect); end
    n_checks++; if (pio_if.pio_write_n !== 1'b1) begin n_errors++; $display("FAIL single_wn_c3: got %b expected 1", pio_if.pio_write_n); end
    n_checks++; if (ack !== 4'b0000) begin n_errors++; $display("FAIL single_ack_c3: got %b expected 0000", ack); end
    step('0, '0);
    n_checks++; if (ack !== 4'b0010) begin n_errors++; $display("FAIL single_ack_c4: got %b expected 0010", ack); end
    n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL single_err_c4: got %b expected 0", err); end
    n_checks++; if (cur_value !== 8'hA5) begin n_errors++; $display("FAIL single_cur: got %h expected a5", cur_value); end
    n_checks++; if (pio_if.pio_chipselect !== 1'b0) begin n_errors++; $display("FAIL single_cs_c4: got %b expected 0", pio_if.pio_chipselect); end
    step('0, '0);
    n_checks++; if (ack !== 4'b0000) begin n_errors++; $display("FAIL single_ack_c5: got %b expected 0000", ack); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL single_busy_c5: got %b expected 0", busy); end
  endtask

  task automatic test_simultaneous();
    logic [N-1:0] exp;
    apply_reset();
    step(4'b0101, {8'h00, 8'h33, 8'h00, 8'h11});
    for (int c = 1; c <= 12; c++) begin
      exp = (c == 4) ? 4'b0001 : (c == 8) ? 4'b0100 : 4'b0000;
      n_checks++; if (ack !== exp) begin n_errors++; $display("FAIL simul_ack_c%0d: got %b expected %b", c, ack, exp); end
      if (c < 12) step('0, '0);
    end
    n_checks++; if (cur_value !== 8'h33) begin n_errors++; $display("FAIL simul_cur: got %h expected 33", cur_value); end
    // pointer now at 3, so ch3 must win over ch0
    step(4'b1001, {8'hC3, 8'h00, 8'h00, 8'hC0});
    for (int c = 1; c <= 9; c++) begin
      exp = (c == 4) ? 4'b1000 : (c == 8) ? 4'b0001 : 4'b0000;
      n_checks++; if (ack !== exp) begin n_errors++; $display("FAIL ptr_ack_c%0d: got %b expected %b", c, ack, exp); end
      if (c < 9) step('0, '0);
    end
    n_checks++; if (cur_value !== 8'hC0) begin n_errors++; $display("FAIL ptr_cur: got %h expected c0", cur_value); end
  endtask

  task automatic test_fairness();
    logic [7:0]     last[N];
    int             cnt[N];
    logic [8*N-1:0] d;
    logic [N-1:0]   nreq;
    int             nacks = 0;
    int             cycles = 0;
    int             idx;
    apply_reset();
    d = $urandom;
    for (int i = 0; i < N; i++) begin
      last[i] = d[8*i +: 8];
      cnt[i]  = 0;
    end
    step(4'b1111, d);
    while (nacks < 12 && cycles < 100) begin
      nreq = '0;
      if (ack !== '0) begin
        idx = 0;
        for (int i = 0; i < N; i++) if (ack[i]) idx = i;
        n_checks++; if (ack !== (N'(1) << (nacks % N))) begin n_errors++; $display("FAIL fair_order_%0d: got %b expected %b", nacks, ack, N'(1) << (nacks % N)); end
        n_checks++; if (cur_value !== last[nacks % N]) begin n_errors++; $display("FAIL fair_cur_%0d: got %h expected %h", nacks, cur_value, last[nacks % N]); end
        cnt[idx]++;
        nacks++;
        nreq = ack;
      end
      d = $urandom;
      for (int i = 0; i < N; i++) if (nreq[i]) last[i] = d[8*i +: 8];
      step(nreq, d);
      cycles++;
    end
    n_checks++; if (nacks != 12) begin n_errors++; $display("FAIL fair_timeout: got %0d acks expected 12", nacks); end
    for (int i = 0; i < N; i++) begin
      n_checks++; if (cnt[i] != 3) begin n_errors++; $display("FAIL fair_count_ch%0d: got %0d expected 3", i, cnt[i]); end
    end
  endtask

  task automatic test_overwrite();
    logic [N-1:0]   r;
    logic [8*N-1:0] d;
    int a0 = 0;
    int a3 = 0;
    apply_reset();
    wr_log.delete();
    for (int c = 0; c < 20; c++) begin
      r = (c == 0) ? 4'b0001 : (c == 2 || c == 4) ? 4'b1000 : 4'b0000;
      d = (c == 0) ? 32'h00000055 : (c == 2) ? 32'h01000000 : (c == 4) ? 32'h02000000 : 32'h0;
      step(r, d);
      if (ack[0] === 1'b1) a0++;
      if (ack[3] === 1'b1) a3++;
      if (c == 7) begin
        n_checks++; if (ack !== 4'b1000) begin n_errors++; $display("FAIL ovw_ack3_c8: got %b expected 1000", ack); end
      end
    end
    n_checks++; if (a0 != 1) begin n_errors++; $display("FAIL ovw_ack0_count: got %0d expected 1", a0); end
    n_checks++; if (a3 != 1) begin n_errors++; $display("FAIL ovw_ack3_count: got %0d expected 1", a3); end
    n_checks++; if (wr_log.size() != 2) begin n_errors++; $display("FAIL ovw_writes: got %0d expected 2", wr_log.size()); end
    if (wr_log.size() >= 2) begin
      n_checks++; if (wr_log[0] !== 8'h55) begin n_errors++; $display("FAIL ovw_write0: got %h expected 55", wr_log[0]); end
      n_checks++; if (wr_log[1] !== 8'h02) begin n_errors++; $display("FAIL ovw_write1: got %h expected 02", wr_log[1]); end
    end
    n_checks++; if (cur_value !== 8'h02) begin n_errors++; $display("FAIL ovw_cur: got %h expected 02", cur_value); end
  endtask

  task automatic test_mismatch();
    int n_ack = 0;
    int n_err = 0;
    int n_lone = 0;
    apply_reset();
    force_bad = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step((c == 0) ? 4'b0001 : 4'b0000, 32'h0000007E);
      if (ack !== '0) n_ack++;
      if (err === 1'b1) n_err++;
      if (err === 1'b1 && ack !== 4'b0001) n_lone++;
      if (c == 3) begin
        n_checks++; if (err !== 1'b1) begin n_errors++; $display("FAIL mm_err_c4: got %b expected 1", err); end
      end
    end
    force_bad = 1'b0;
    n_checks++; if (n_ack != 1) begin n_errors++; $display("FAIL mm_ack_cycles: got %0d expected 1", n_ack); end
    n_checks++; if (n_err != 1) begin n_errors++; $display("FAIL mm_err_cycles: got %0d expected 1", n_err); end
    n_checks++; if (n_lone != 0) begin n_errors++; $display("FAIL mm_err_without_ack: got %0d expected 0", n_lone); end
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] exp;
    logic [8*N-1:0] d;
    apply_reset();
    step(4'b0111, {8'h00, 8'h23, 8'h22, 8'h21});
    step('0, '0);
    step('0, '0);
    n_checks++; if (pio_if.pio_chipselect !== 1'b1) begin n_errors++; $display("FAIL rmid_cs_read: got %b expected 1", pio_if.pio_chipselect); end
    #1 reset_n = 1'b0;
    #1;
    n_checks++; if (pio_if.pio_chipselect !== 1'b0) begin n_errors++; $display("FAIL rmid_cs_async: got %b expected 0", pio_if.pio_chipselect); end
    n_checks++; if (pio_if.pio_write_n !== 1'b1) begin n_errors++; $display("FAIL rmid_wn_async: got %b expected 1", pio_if.pio_write_n); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rmid_busy_async: got %b expected 0", busy); end
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    for (int c = 0; c < 8; c++) begin
      step('0, '0);
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rmid_busy_c%0d: got %b expected 0", c, busy); end
      n_checks++; if (ack !== '0) begin n_errors++; $display("FAIL rmid_ack_c%0d: got %b expected 0", c, ack); end
    end
    d = '0;
    d[23:16] = 8'h5A;
    step(4'b0100, d);
    for (int c = 1; c <= 6; c++) begin
      exp = (c == 4) ? 4'b0100 : 4'b0000;
      n_checks++; if (ack !== exp) begin n_errors++; $display("FAIL rmid_new_ack_c%0d: got %b expected %b", c, ack, exp); end
      if (c < 6) step('0, '0);
    end
    n_checks++; if (cur_value !== 8'h5A) begin n_errors++; $display("FAIL rmid_cur: got %h expected 5a", cur_value); end
  endtask

  task automatic test_random();
    logic [N-1:0]   r;
    logic [8*N-1:0] d;
    logic           e_busy;
    logic           e_cs;
    logic           e_wn;
    apply_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < N; i++) r[i] = ($urandom_range(3) == 0);
      d = $urandom;
      force_bad = ($urandom_range(7) == 0);
      step(r, d);
      e_busy = (m_a != 0) || m_any();
      e_cs   = (m_a == 1) || (m_a == 2);
      e_wn   = (m_a != 1);
      n_checks++; if (ack !== e_ack) begin n_errors++; $display("FAIL rnd_ack@%0d: got %b expected %b", cyc, ack, e_ack); end
      n_checks++; if (err !== e_err) begin n_errors++; $display("FAIL rnd_err@%0d: got %b expected %b", cyc, err, e_err); end
      n_checks++; if (busy !== e_busy) begin n_errors++; $display("FAIL rnd_busy@%0d: got %b expected %b", cyc, busy, e_busy); end
      n_checks++; if (cur_value !== m_cur) begin n_errors++; $display("FAIL rnd_cur@%0d: got %h expected %h", cyc, cur_value, m_cur); end
      n_checks++; if (pio_if.pio_chipselect !== e_cs) begin n_errors++; $display("FAIL rnd_cs@%0d: got %b expected %b", cyc, pio_if.pio_chipselect, e_cs); end
      n_checks++; if (pio_if.pio_write_n !== e_wn) begin n_errors++; $display("FAIL rnd_wn@%0d: got %b expected %b", cyc, pio_if.pio_write_n, e_wn); end
      n_checks++; if (pio_if.pio_writedata !== {24'h0, m_b}) begin n_errors++; $display("FAIL rnd_wdata@%0d: got %h expected %h", cyc, pio_if.pio_writedata, {24'h0, m_b}); end
      n_checks++; if (pio_if.pio_address !== 2'b00) begin n_errors++; $display("FAIL rnd_addr@%0d: got %b expected 00", cyc, pio_if.pio_address); end
    end
    force_bad = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset_n   = 1'b0;
    req       = '0;
    req_data  = '0;
    force_bad = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_overwrite();
    test_mismatch();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
